ibex_multdiv_iter: RTL and testbench
====================================

# ibex_multdiv_iter

Parametrised, self-contained iterative multiply/divide unit for RV32M/RV64M-style operations. It supersedes the ALU-sharing fast multdiv: it owns its adder, accumulator and intermediate registers, generalises the datapath to `WIDTH` bits with a configurable multiplier radix, and adds a valid/ready request/response handshake with kill. It sits beside the ALU in the EX stage, driven by the ID stage.

## Interface
- `WIDTH`, 32: operand and result width. Must be even and ≥ 8.
- `MUL_BITS`, 8: multiplier bits retired per cycle. Must satisfy `WIDTH % MUL_BITS == 0`.
- `clk_i` in 1: clock.
- `rst_i` in 1: reset. **One clock; reset is synchronous and active-high.**
- `req_valid_i` in 1: request present.
- `req_ready_o` out 1: unit can accept a request.
- `req_op_i` in 3: `md_op_e` code: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- `op_a_i` in `WIDTH`: multiplicand or dividend.
- `op_b_i` in `WIDTH`: multiplier or divisor.
- `data_ind_timing_i` in 1: forces the full latency; no fast path.
- `kill_i` in 1: abort the in-flight operation.
- `resp_valid_o` out 1: result available.
- `resp_ready_i` in 1: consumer takes the result.
- `resp_data_o` out `WIDTH`: result.

## Operation
- **States:** IDLE, ITER, FIX, DONE.
- **IDLE:** `req_ready_o = 1`. On `req_valid_i` the unit latches the op, the operand signs and the operand magnitudes (two's-complement absolute value where the op is signed), clears the accumulator, and moves to ITER.
- **Counter:** loads N−1 on accept, where N = `WIDTH/MUL_BITS` for multiply and N = `WIDTH` for divide.
- **Multiply (ITER):** unsigned shift-add.
  - Each cycle adds `|a| * |b|[MUL_BITS-1:0]` to the upper half of a 2·`WIDTH` accumulator.
  - The accumulator then shifts right `MUL_BITS`, and `|b|` shifts right `MUL_BITS`.
- **Divide (ITER):** radix-2 restoring division through sub-module `ibex_multdiv_divstep`.
  - Remainder width is `WIDTH+1`.
  - Each cycle shifts in one dividend bit, MSB first, and produces one quotient bit.
- **Exit from ITER:** when the counter reaches 0 the unit moves to FIX.
- **FIX:** applies the sign correction.
  - Product is negated if sign(a) XOR sign(b) for the signed ops. MULHSU uses only the sign of a.
  - Quotient is negated if the signs differ.
  - Remainder takes the sign of the dividend.
  - The result is selected: low half for MUL, high half for MULH*, quotient for DIV*, remainder for REM*.
  - It is registered into `resp_data_o`. Next state is DONE.
- **DONE:** `resp_valid_o = 1`, and `resp_data_o` is held stable. On `resp_ready_i` the unit goes to IDLE.
- **Divide by zero:** quotient = all ones, remainder = `op_a_i`.
- **Signed overflow** (`op_a_i` = MIN and `op_b_i` = −1): quotient = MIN, remainder = 0.
- **Kill:** `kill_i` in ITER, FIX or DONE returns the unit to IDLE next cycle and discards the result. `kill_i` in IDLE has no effect. Kill takes priority over `resp_ready_i`.
- **Reset:** `rst_i` has priority over everything. It is valid mid-operation and returns the unit to IDLE.

## Timing
- **Reset values:** `req_ready_o = 1`, `resp_valid_o = 0`, `resp_data_o = 0`, state = IDLE, counter = 0.
- **Request handshake:** accepted on the edge where `req_valid_i` and `req_ready_o` are both 1 (cycle t).
- **Multiply latency:** ITER occupies t+1 … t+N, FIX is t+N+1, and `resp_valid_o` rises at t+N+2. With the defaults this is 6 cycles.
- **Divide latency:** `resp_valid_o` rises at t+`WIDTH`+2, i.e. 34 cycles.
- **Response handshake:** the result is consumed on the edge where `resp_valid_o` and `resp_ready_i` are both 1. `req_ready_o` returns on the next cycle.
- **Throughput:** at most one operation in flight. No new request is accepted while in DONE.
- **Latency independence:** latency does not depend on operand values except through the configured fast path.

## Configuration
- **Macro:** `IBEX_MULTDIV_ITER_FAST_PATH_EN`.
- **Defined:** when `data_ind_timing_i = 0`, divide-by-zero and signed overflow skip ITER and FIX. The special result is registered directly and `resp_valid_o` rises at t+1.
- **Not defined:** every operation takes the full latency. The special results still come out of the normal datapath. `data_ind_timing_i` is unused, but the port is kept.

## Structure
- **Package `ibex_multdiv_pkg`:** holds
  - `md_op_e`, 3-bit encoding in the order listed under Interface;
  - `md_state_e`;
  - helper functions `is_signed_a(op)`, `is_signed_b(op)` and `is_div(op)`.
- **Sub-module `ibex_multdiv_divstep`:** combinational, parameter `WIDTH`.
  - Inputs: remainder, divisor magnitude, incoming bit.
  - Outputs: next remainder and quotient bit.
- **Top level:** the FSM, the counter and the shift-add multiplier stay in `ibex_multdiv_iter`.

## Test plan
All scenarios use the defaults `WIDTH = 32`, `MUL_BITS = 8`.
- **MUL:** 7 × 0xFFFFFFFD → 0xFFFFFFEB, with `resp_valid_o` at t+6.
- **MULH, MULHU, MULHSU:** operands 0x80000000 × 0x80000000 → 0x40000000 / 0x40000000 / 0xC0000000.
- **Signed divide:** DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD, REM → 0xFFFFFFFF, latency 34.
- **Special cases:**
  - DIVU 5 / 0 → 0xFFFFFFFF; REMU 5 / 0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0.
  - Latency is 1 cycle with the macro defined and `data_ind_timing_i = 0`; otherwise 34.
- **Backpressure:** hold `resp_ready_i = 0` for 10 cycles. The result must stay stable and `req_ready_o` must stay 0. Release → IDLE on the next cycle.
- **Kill and reset:**
  - Assert `kill_i` at ITER cycle 3: no `resp_valid_o`, `req_ready_o = 1` on the next cycle, and the next DIVU 100 / 7 → 14.
  - Assert `rst_i` mid-divide: all outputs return to their reset values.

Source files
------------

// File: rtl/ibex_multdiv_pkg.sv
// Shared types and op-class helpers for the iterative multiply/divide unit.
package ibex_multdiv_pkg;

    typedef enum logic [2:0] {
        MD_MUL,
        MD_MULH,
        MD_MULHSU,
        MD_MULHU,
        MD_DIV,
        MD_DIVU,
        MD_REM,
        MD_REMU
    } md_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_FIX,
        S_DONE
    } md_state_e;

    function automatic logic is_signed_a(input md_op_e op);
        return op inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
    endfunction

    function automatic logic is_signed_b(input md_op_e op);
        return op inside {MD_MULH, MD_DIV, MD_REM};
    endfunction

    function automatic logic is_div(input md_op_e op);
        return op[2];
    endfunction

endpackage

// File: rtl/ibex_multdiv_divstep.sv
// One radix-2 restoring division step: shift in a dividend bit, try subtract.
module ibex_multdiv_divstep
    import ibex_multdiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   i_rem,
    input  logic [WIDTH-1:0] i_div,
    input  logic             i_bit,
    output logic [WIDTH:0]   o_rem,
    output logic             o_q
);

    logic [WIDTH+1:0] w_diff;

    assign w_diff = {i_rem, i_bit} - {2'b00, i_div};
    assign o_q    = ~w_diff[WIDTH+1];
    assign o_rem  = o_q ? w_diff[WIDTH:0] : {i_rem[WIDTH-1:0], i_bit};

endmodule

// File: rtl/ibex_multdiv_iter.sv
// Iterative multiply/divide unit with valid/ready handshake and kill.
// Define IBEX_MULTDIV_ITER_FAST_PATH_EN for 1-cycle div-by-zero/overflow.
module ibex_multdiv_iter
    import ibex_multdiv_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MUL_BITS = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [2:0]       req_op_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    input  logic             data_ind_timing_i,
    input  logic             kill_i,
    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic [WIDTH-1:0] resp_data_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] NMUL = CW'(WIDTH / MUL_BITS - 1);
    localparam logic [CW-1:0] NDIV = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

    md_state_e          r_state, w_next;
    md_op_e             r_op, w_op;
    logic               r_sa, r_sb, r_bz;
    logic [WIDTH-1:0]   r_a, r_b, r_quo, r_result;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH:0]     r_rem;
    logic [CW-1:0]      r_cnt;

    logic                      w_sa, w_sb, w_bz, w_ovf, w_fast, w_q;
    logic [WIDTH-1:0]          w_mag_a, w_mag_b, w_fast_res, w_fix_res;
    logic [WIDTH-1:0]          w_quo, w_rem;
    logic [2*WIDTH-1:0]        w_prod;
    logic [WIDTH+MUL_BITS-1:0] w_pp, w_sum;
    logic [WIDTH:0]            w_rem_nxt;

    assign w_op    = md_op_e'(req_op_i);
    assign w_sa    = is_signed_a(w_op) & op_a_i[WIDTH-1];
    assign w_sb    = is_signed_b(w_op) & op_b_i[WIDTH-1];
    assign w_mag_a = w_sa ? -op_a_i : op_a_i;
    assign w_mag_b = w_sb ? -op_b_i : op_b_i;
    assign w_bz    = (op_b_i == '0);
    assign w_ovf   = is_signed_b(w_op) & is_div(w_op)
                   & (op_a_i == MIN) & (&op_b_i);

    // op[1] separates REM* from DIV* within the divide group
    assign w_fast_res = w_op[1] ? (w_bz ? op_a_i : '0)
                                : (w_bz ? '1 : MIN);

`ifdef IBEX_MULTDIV_ITER_FAST_PATH_EN
    assign w_fast = ~data_ind_timing_i & is_div(w_op) & (w_bz | w_ovf);
`else
    logic w_unused_dit;
    assign w_unused_dit = data_ind_timing_i;
    assign w_fast       = 1'b0;
`endif

    assign w_pp  = {{MUL_BITS{1'b0}}, r_a}
                 * {{WIDTH{1'b0}}, r_b[MUL_BITS-1:0]};
    assign w_sum = {{MUL_BITS{1'b0}}, r_acc[2*WIDTH-1:WIDTH]} + w_pp;

    ibex_multdiv_divstep #(
        .WIDTH (WIDTH)
    ) u_divstep (
        .i_rem (r_rem),
        .i_div (r_b),
        .i_bit (r_a[WIDTH-1]),
        .o_rem (w_rem_nxt),
        .o_q   (w_q)
    );

    assign w_prod = (r_sa ^ r_sb) ? -r_acc : r_acc;
    assign w_quo  = r_bz ? '1 : ((r_sa ^ r_sb) ? -r_quo : r_quo);
    assign w_rem  = r_sa ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];

    always_comb begin
        w_fix_res = w_rem;
        unique case (r_op)
            MD_MUL:                       w_fix_res = w_prod[WIDTH-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: w_fix_res = w_prod[2*WIDTH-1:WIDTH];
            MD_DIV, MD_DIVU:              w_fix_res = w_quo;
            default:                      w_fix_res = w_rem;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (req_valid_i) w_next = w_fast ? S_DONE : S_ITER;
            S_ITER: begin
                if (kill_i)              w_next = S_IDLE;
                else if (r_cnt == '0)    w_next = S_FIX;
            end
            S_FIX:  w_next = kill_i ? S_IDLE : S_DONE;
            S_DONE: if (kill_i || resp_ready_i) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_op     <= MD_MUL;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_bz     <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_quo    <= '0;
            r_acc    <= '0;
            r_rem    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: if (req_valid_i) begin
                    r_op  <= w_op;
                    r_sa  <= w_sa;
                    r_sb  <= w_sb;
                    r_bz  <= w_bz;
                    r_a   <= w_mag_a;
                    r_b   <= w_mag_b;
                    r_quo <= '0;
                    r_acc <= '0;
                    r_rem <= '0;
                    r_cnt <= is_div(w_op) ? NDIV : NMUL;
                    if (w_fast) r_result <= w_fast_res;
                end
                S_ITER: begin
                    if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
                    if (is_div(r_op)) begin
                        r_rem <= w_rem_nxt;
                        r_quo <= {r_quo[WIDTH-2:0], w_q};
                        r_a   <= r_a << 1;
                    end else begin
                        r_acc <= {w_sum, r_acc[WIDTH-1:MUL_BITS]};
                        r_b   <= r_b >> MUL_BITS;
                    end
                end
                S_FIX: if (!kill_i) r_result <= w_fix_res;
                default: ;
            endcase
        end
    end

    assign req_ready_o  = (r_state == S_IDLE);
    assign resp_valid_o = (r_state == S_DONE);
    assign resp_data_o  = r_result;

endmodule

// File: tb/tb_ibex_multdiv_iter.sv
// Scoreboard bench for ibex_multdiv_iter: directed vectors, latency,
// backpressure, kill and mid-operation reset.
module tb_ibex_multdiv_iter;
    import ibex_multdiv_pkg::*;

`ifdef IBEX_MULTDIV_ITER_FAST_PATH_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = '0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        dit = 1'b0;
    logic        kill = 1'b0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_data;

    typedef struct {
        logic [31:0] d;
        int          t;
        int          lat;
        int          id;
    } exp_t;

    typedef struct {
        md_op_e      op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e;
        int          lat;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[15];
    int   n_run = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   id_ctr = 0;
    bit   prev_v = 1'b0;

    ibex_multdiv_iter dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .req_valid_i       (req_valid),
        .req_ready_o       (req_ready),
        .req_op_i          (req_op),
        .op_a_i            (op_a),
        .op_b_i            (op_b),
        .data_ind_timing_i (dit),
        .kill_i            (kill),
        .resp_valid_o      (resp_valid),
        .resp_ready_i      (resp_ready),
        .resp_data_o       (resp_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (resp_valid && !prev_v) begin
                if (sb.size() == 0) begin
                    n_run++;
                    n_fail++;
                    $display("FAIL unexpected_resp: got 0x%08h expected none",
                             resp_data);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("resp%0d_data", e.id), resp_data, e.d);
                    chk($sformatf("resp%0d_lat", e.id), 32'(cyc - e.t),
                        32'(e.lat));
                end
            end
            prev_v = resp_valid;
        end
    endtask

    task automatic issue(input md_op_e op, input logic [31:0] a,
                         input logic [31:0] b, input logic d, input bit push,
                         input logic [31:0] e, input int lat);
        int g = 0;
        @(negedge clk);
        while (!req_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (!req_ready) begin
            n_run++;
            n_fail++;
            $display("FAIL req_ready_timeout: got 0 expected 1");
        end
        req_valid = 1'b1;
        req_op    = op;
        op_a      = a;
        op_b      = b;
        dit       = d;
        if (push) begin
            sb.push_back('{e, cyc, lat, id_ctr});
            id_ctr++;
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        while ((sb.size() != 0 || resp_valid) && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (sb.size() != 0) begin
            n_run++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending expected 0",
                     sb.size());
            sb.delete();
        end
    endtask

    initial begin
        int  g;
        int  lat;
        bit  seen;

        vecs = '{
            '{MD_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 6},
            '{MD_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 6},
            '{MD_MULHU,  32'h80000000, 32'h80000000, 32'h40000000, 6},
            '{MD_MULHSU, 32'h80000000, 32'h80000000, 32'hC0000000, 6},
            '{MD_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 6},
            '{MD_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 6},
            '{MD_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34},
            '{MD_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34},
            '{MD_REMU,   32'd100,      32'd7,        32'd2,        34},
            '{MD_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 0},
            '{MD_REMU,   32'd5,        32'd0,        32'd5,        0},
            '{MD_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0},
            '{MD_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 0},
            '{MD_DIV,    32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 0},
            '{MD_REM,    32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 0}
        };

        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        rst = 1'b0;

        for (int d = 0; d < 2; d++) begin
            foreach (vecs[i]) begin
                if (vecs[i].lat != 0) lat = vecs[i].lat;
                else lat = (FAST && d == 0) ? 1 : 34;
                issue(vecs[i].op, vecs[i].a, vecs[i].b, d[0], 1'b1,
                      vecs[i].e, lat);
                drain();
            end
        end

        resp_ready = 1'b0;
        issue(MD_MUL, 32'd3, 32'd5, 1'b0, 1'b1, 32'd15, 6);
        g = 0;
        while (!resp_valid && g < 50) begin
            @(negedge clk);
            g++;
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("bp_data", resp_data, 32'd15);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            chk("bp_resp_valid", 32'(resp_valid), 32'd1);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        chk("bp_rel_valid", 32'(resp_valid), 32'd0);
        chk("bp_rel_ready", 32'(req_ready), 32'd1);

        issue(MD_DIVU, 32'd1000, 32'd3, 1'b0, 1'b0, 32'd0, 0);
        @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        chk("kill_req_ready", 32'(req_ready), 32'd1);
        chk("kill_resp_valid", 32'(resp_valid), 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (resp_valid) seen = 1'b1;
        end
        chk("kill_no_resp", 32'(seen), 32'd0);
        issue(MD_DIVU, 32'd100, 32'd7, 1'b0, 1'b1, 32'd14, 34);
        drain();

        issue(MD_DIVU, 32'd100, 32'd7, 1'b0, 1'b0, 32'd0, 0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_req_ready", 32'(req_ready), 32'd1);
        chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
        chk("midrst_resp_data", resp_data, 32'd0);
        rst = 1'b0;
        issue(MD_REMU, 32'd100, 32'd7, 1'b0, 1'b1, 32'd2, 34);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
